// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encoding and parity helper, common to the transmit and receive paths.
package uart_pkg;

  localparam int   PRESCALE_W = 5;
  localparam int   MAX_DATA_W = 9;
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic LINE_IDLE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Zero-extension to MAX_DATA_W leaves the XOR reduction unchanged for narrower words.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic par_typ);
    return (^data) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word-source handshake plus serial line of uart_tx_frame; the source uses master, the transmitter slave.
interface uart_tx_frame_if import uart_pkg::*; #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output prescale,
    output par_en,
    output par_typ,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  prescale,
    input  par_en,
    input  par_typ,
    output tx_out,
    output busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Data-bit shifter for uart_tx_frame: holds the latched word, the bit index and the last-bit flag.
module uart_tx_serializer import uart_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  next_bit,
  output logic                  done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(DATA_WIDTH - 2);

  logic [DATA_WIDTH-1:0] shreg_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  done_r;

  // Load on accept, shift one place at the end of every data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r <= '0;
      idx_r   <= '0;
      done_r  <= 1'b0;
    end else if (load) begin
      shreg_r <= word;
      idx_r   <= '0;
      done_r  <= 1'b0;
    end else if (shift) begin
      shreg_r <= {1'b0, shreg_r[DATA_WIDTH-1:1]};
      idx_r   <= idx_r + IDX_ONE;
      done_r  <= (idx_r == PRE_LAST_IDX);
    end else begin
      shreg_r <= shreg_r;
      idx_r   <= idx_r;
      done_r  <= done_r;
    end
  end

  // The line flop is loaded with the bit that will be current after this edge.
  assign next_bit = shift ? shreg_r[1] : shreg_r[0];
  assign done     = done_r;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits; the default build sends one.
module uart_tx_frame import uart_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_frame_if.slave    bus
);

  uart_state_e           state_r;
  uart_state_e           next_state_s;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [PRESCALE_W-1:0] cnt_r;
  logic [PRESCALE_W-1:0] cnt_last_s;
  logic                  par_en_r;
  logic                  par_r;
  logic                  tx_r;
  logic                  busy_r;
  logic                  accept_s;
  logic                  bit_end_s;
  logic                  shift_s;
  logic                  next_bit_s;
  logic                  done_s;
  logic                  stop_last_s;
  logic                  tx_next_s;
  logic                  busy_next_s;

  assign accept_s   = (state_r == IDLE) && bus.data_valid && !busy_r;
  // prescale 0 wraps to 31, giving the 32-cycle bit period for free.
  assign cnt_last_s = prescale_r - 5'd1;
  assign bit_end_s  = (cnt_r == cnt_last_s);
  assign shift_s    = (state_r == DATA) && bit_end_s;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_second_r;

  // Tracks which of the two stop bits is on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      stop_second_r <= 1'b0;
    end else if ((state_r == STOP) && bit_end_s) begin
      stop_second_r <= !stop_second_r;
    end else begin
      stop_second_r <= stop_second_r;
    end
  end

  assign stop_last_s = stop_second_r;
`else
  assign stop_last_s = 1'b1;
`endif

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_s),
    .shift    (shift_s),
    .word     (bus.p_data),
    .next_bit (next_bit_s),
    .done     (done_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; every state except IDLE advances only at a bit boundary.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = START;
        else          next_state_s = IDLE;
      end
      START: begin
        if (bit_end_s) next_state_s = DATA;
        else           next_state_s = START;
      end
      DATA: begin
        if (bit_end_s && done_s) next_state_s = par_en_r ? PARITY : STOP;
        else                     next_state_s = DATA;
      end
      PARITY: begin
        if (bit_end_s) next_state_s = STOP;
        else           next_state_s = PARITY;
      end
      STOP: begin
        if (bit_end_s && stop_last_s) next_state_s = IDLE;
        else                          next_state_s = STOP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode from the next state, so the line and busy flops change with the state.
  always_comb begin
    tx_next_s   = LINE_IDLE;
    busy_next_s = 1'b1;
    case (next_state_s)
      IDLE: begin
        tx_next_s   = LINE_IDLE;
        busy_next_s = 1'b0;
      end
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = next_bit_s;
      PARITY:  tx_next_s = par_r;
      STOP:    tx_next_s = LINE_IDLE;
      default: begin
        tx_next_s   = LINE_IDLE;
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Frame configuration latch, bit-period counter and registered line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_r <= '0;
      par_en_r   <= 1'b0;
      par_r      <= 1'b0;
      cnt_r      <= '0;
      tx_r       <= LINE_IDLE;
      busy_r     <= 1'b0;
    end else begin
      tx_r   <= tx_next_s;
      busy_r <= busy_next_s;
      if (accept_s) begin
        prescale_r <= bus.prescale;
        par_en_r   <= bus.par_en;
        par_r      <= parity_bit(MAX_DATA_W'(bus.p_data), bus.par_typ);
      end else begin
        prescale_r <= prescale_r;
        par_en_r   <= par_en_r;
        par_r      <= par_r;
      end
      if ((state_r == IDLE) || bit_end_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 5'd1;
      end
    end
  end

  assign bus.tx_out = tx_r;
  assign bus.busy   = busy_r;

endmodule
